// File: rtl/add_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock through a
// registered carry, start/busy/done handshake, result held until the next done.
module add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] sum;
  logic             c_out, c_msb;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;

  assign {c_out, sum} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};
  // Carry into the chunk's top bit; on the last chunk this is the carry into the MSB.
  assign c_msb = sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  generate
    if (CHUNK == WIDTH) begin : g_one
      assign a_sh   = '0;
      assign b_sh   = '0;
      assign res_sh = sum;
    end else begin : g_multi
      assign a_sh   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
      assign b_sh   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
      assign res_sh = {sum, res_q[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_sh;
        b_d     = b_sh;
        res_d   = res_sh;
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          out_d   = res_sh;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: directed 8-bit vectors and corner sequences, then random
// 32-bit operations against an arithmetic reference for CHUNK = 1, 4, 32.
module tb_add_seq;
  logic clk, rst_n;

  logic       s8_start, s8_sub, s8_cin, s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0] s8_a, s8_b, s8_out;

  logic        st32 [3];
  logic        sb32 [3];
  logic        ci32 [3];
  logic [31:0] a32  [3];
  logic [31:0] b32  [3];
  logic [31:0] o32  [3];
  logic        bz32 [3];
  logic        dn32 [3];
  logic        co32 [3];
  logic        ov32 [3];

  int checks = 0;
  int errors = 0;

  add_seq #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub), .a(s8_a), .b(s8_b),
    .cin(s8_cin), .busy(s8_busy), .done(s8_done), .out(s8_out), .cout(s8_cout), .ovf(s8_ovf)
  );

  for (genvar g = 0; g < 3; g++) begin : g32
    localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : 32;
    add_seq #(.WIDTH(32), .CHUNK(CH)) u (
      .clk(clk), .rst_n(rst_n), .start(st32[g]), .sub(sb32[g]), .a(a32[g]), .b(b32[g]),
      .cin(ci32[g]), .busy(bz32[g]), .done(dn32[g]), .out(o32[g]), .cout(co32[g]), .ovf(ov32[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the spec's rules.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, b,
                                         input logic sub, cin);
    logic [32:0] full;
    logic [31:0] bb, mask;
    logic        sa, sbb, sr, co, ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bb} + {32'd0, cin};
    sa   = a[w-1];
    sbb  = bb[w-1];
    sr   = full[w-1];
    co   = full[w];
    ov   = (sa == sbb) && (sr != sa);
    return {co, ov, full[31:0] & mask};
  endfunction

  typedef struct {
    logic [7:0] a, b;
    logic       sub, cin;
    logic [7:0] e_out;
    logic       e_cout, e_ovf;
  } vec_t;

  // One 8-bit operation; optional disturbance of inputs during RUN.
  task automatic run8(input logic [7:0] a, b, input logic sub, cin, input bit disturb,
                      output int lat);
    logic [7:0] prev;
    prev = s8_out;
    s8_a = a; s8_b = b; s8_sub = sub; s8_cin = cin; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    lat = 0;
    chk("busy8_accept", {63'd0, s8_busy}, 64'd1);
    if (disturb) begin
      s8_start = 1'b1; s8_a = ~a; s8_b = ~b; s8_sub = ~sub; s8_cin = ~cin;
    end
    for (int m = 1; m <= 10; m++) begin
      @(posedge clk); #1;
      if (s8_done) begin lat = m; break; end
      chk("busy8_run", {63'd0, s8_busy}, 64'd1);
      chk("out8_hold", {56'd0, s8_out}, {56'd0, prev});
    end
    s8_start = 1'b0;
    if (lat == 0) begin
      errors++;
      $display("FAIL done8_timeout: no done within 10 cycles");
    end else begin
      chk("busy8_done", {63'd0, s8_busy}, 64'd0);
    end
  endtask

  task automatic rand32(input int k, input int nexp);
    logic [31:0] ra, rb;
    logic        rs, rc;
    logic [33:0] e;
    int          lat, idle;
    ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
    a32[k] = ra; b32[k] = rb; sb32[k] = rs; ci32[k] = rc; st32[k] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      // Scramble inputs during RUN; the latched operands must win.
      st32[k] = 1'($urandom_range(0, 1)); a32[k] = $urandom; b32[k] = $urandom;
      sb32[k] = 1'($urandom_range(0, 1)); ci32[k] = 1'($urandom_range(0, 1));
      lat = 0;
      for (int m = 1; m <= 40; m++) begin
        @(posedge clk); #1;
        if (dn32[k]) begin lat = m; break; end
        chk("busy32_run", {63'd0, bz32[k]}, 64'd1);
      end
      if (lat == 0) begin
        errors++;
        $display("FAIL done32_timeout: chunk cfg %0d op %0d", k, i);
        st32[k] = 1'b0;
        return;
      end
      e = ref_op(32, ra, rb, rs, rc);
      chk("lat32", 64'(lat), 64'(nexp));
      chk("out32", {32'd0, o32[k]}, {32'd0, e[31:0]});
      chk("cout32", {63'd0, co32[k]}, {63'd0, e[33]});
      chk("ovf32", {63'd0, ov32[k]}, {63'd0, e[32]});
      chk("busy32_done", {63'd0, bz32[k]}, 64'd0);
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      a32[k] = ra; b32[k] = rb; sb32[k] = rs; ci32[k] = rc;
      if ($urandom_range(0, 3) != 0) begin
        st32[k] = 1'b1;
      end else begin
        st32[k] = 1'b0;
        idle = $urandom_range(1, 2);
        for (int j = 0; j < idle; j++) begin
          @(posedge clk); #1;
          chk("done32_idle", {63'd0, dn32[k]}, 64'd0);
        end
        st32[k] = 1'b1;
      end
    end
    @(posedge clk); #1;
    st32[k] = 1'b0;
  endtask

  initial begin
    vec_t vecs [7];
    int   lat;
    rst_n = 1'b0;
    s8_start = 1'b0; s8_sub = 1'b0; s8_cin = 1'b0; s8_a = '0; s8_b = '0;
    for (int k = 0; k < 3; k++) begin
      st32[k] = 1'b0; sb32[k] = 1'b0; ci32[k] = 1'b0; a32[k] = '0; b32[k] = '0;
    end
    vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'h7F, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy8", {63'd0, s8_busy}, 64'd0);
    chk("rst_done8", {63'd0, s8_done}, 64'd0);
    chk("rst_out8", {56'd0, s8_out}, 64'd0);
    chk("rst_cout8", {63'd0, s8_cout}, 64'd0);
    chk("rst_ovf8", {63'd0, s8_ovf}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy32", {63'd0, bz32[k]}, 64'd0);
      chk("rst_out32", {32'd0, o32[k]}, 64'd0);
    end

    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, 1'b0, lat);
      chk("lat8", 64'(lat), 64'd2);
      chk("out8", {56'd0, s8_out}, {56'd0, vecs[i].e_out});
      chk("cout8", {63'd0, s8_cout}, {63'd0, vecs[i].e_cout});
      chk("ovf8", {63'd0, s8_ovf}, {63'd0, vecs[i].e_ovf});
      @(posedge clk); #1;
      chk("done8_pulse", {63'd0, s8_done}, 64'd0);
      chk("out8_held", {56'd0, s8_out}, {56'd0, vecs[i].e_out});
    end

    // Inputs toggled during RUN must not leak into the result or retrigger.
    run8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, lat);
    chk("lat8_dist", 64'(lat), 64'd2);
    chk("out8_dist", {56'd0, s8_out}, 64'h46);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("done8_extra", {63'd0, s8_done}, 64'd0);
      chk("busy8_extra", {63'd0, s8_busy}, 64'd0);
    end

    // Reset in the middle of an operation abandons it.
    s8_a = 8'h01; s8_b = 8'h02; s8_sub = 1'b0; s8_cin = 1'b0; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy8", {63'd0, s8_busy}, 64'd0);
    chk("rstmid_done8", {63'd0, s8_done}, 64'd0);
    chk("rstmid_out8", {56'd0, s8_out}, 64'd0);
    #3 rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk("rstmid_nodone8", {63'd0, s8_done}, 64'd0);
    end

    rand32(0, 32);
    rand32(1, 8);
    rand32(2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
